linecard_ingress_scheduler: RTL and testbench
=============================================

Name: linecard_ingress_scheduler

Overview:
- Round-robin scheduler that picks which of a line card's NUM_PORTS ingress FIFOs the cascaded-URAM FIFO reader services next.
- Watches per-port committed write pointers vs read pointers, grants one port at a time to the reader over a valid/ready handshake, and holds that port busy until the reader reports the frame done.
- Includes a busy watchdog and a port-reset abort.
- Sits between the per-port ingress FIFO controllers and the line-card FIFO reader, in the clk_fabric domain.

Parameters:
- NUM_PORTS, 24, number of ingress FIFOs scheduled.
- PTR_BITS, 13, width of rd_ptr / wr_ptr_committed.
- TIMEOUT_CYCLES, 1024, max cycles in BUSY before forced release; 0 disables the watchdog.
- PORT_BITS, $clog2(NUM_PORTS) (localparam), port index width.

Ports:
- clk  in  1  fabric clock.
- rst  in  1  synchronous active-high reset.
- port_en  in  NUM_PORTS  per-port scheduling enable.
- rd_ptr_reset  in  NUM_PORTS  per-port FIFO reset (high = port in reset).
- rd_ptr  in  PTR_BITS x NUM_PORTS  reader's per-port read pointer.
- wr_ptr_committed  in  PTR_BITS x NUM_PORTS  committed write pointer per port.
- grant_valid  out  1  a port is offered to the reader.
- grant_ready  in  1  reader accepts the offer.
- grant_port  out  PORT_BITS  offered port index.
- done  in  1  single-cycle pulse: reader finished the granted frame.
- done_port  in  PORT_BITS  port index accompanying done.
- abort  out  1  single-cycle pulse: service cancelled (port reset or timeout).
- timeout  out  1  single-cycle pulse: watchdog expired.
- proto_err  out  1  sticky; cleared only by rst.

Behaviour:
- Reset values: grant_valid=0, grant_port=0, abort=0, timeout=0, proto_err=0, state=IDLE, last_grant=NUM_PORTS-1 (so port 0 wins first).
- Registered each cycle:
  - pending[i] = port_en[i] & !rd_ptr_reset[i] & (wr_ptr_committed[i] != rd_ptr[i]).
  - Equality compare only, so pointer wrap needs no special handling.
- States:
  - IDLE: if any pending_q, search starts at last_grant+1 (mod NUM_PORTS) and the first set bit wins. Load grant_port, go OFFER.
  - OFFER: grant_valid=1. grant_port stays stable until handshake.
    - grant_valid & grant_ready: last_grant<=grant_port, go BUSY, clear the watchdog counter.
    - If rd_ptr_reset[grant_port] rises before the handshake: drop grant_valid, pulse abort, go IDLE.
  - BUSY: grant_valid=0, counter increments.
    - done & done_port==grant_port: go IDLE.
    - rd_ptr_reset[grant_port]: pulse abort, go IDLE.
    - counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0): pulse abort and timeout, go IDLE.
- Latency: pending edge in cycle N gives grant_valid in cycle N+2. BUSY->IDLE on done, then next grant_valid no earlier than 2 cycles after done.
- Simultaneous events in BUSY: done wins over port reset and timeout (no abort).
- done with mismatched done_port, or done outside BUSY: sets proto_err, otherwise ignored.
- A port disabled via port_en during BUSY continues to completion.
- Only one outstanding grant at any time.
- rst mid-operation returns everything to reset values in the next cycle. No abort pulse is emitted.

Optional Feature:
- Macro LINECARD_SCHED_STATS_EN.
- Defined: adds input stats_sel (PORT_BITS) and output stats_grants (32 bits, registered, 1-cycle latency).
  - Per-port grant counters increment on each handshake and saturate at 0xFFFFFFFF.
  - Counters are cleared by rst.
- Undefined: no counters, no extra ports, identical scheduling behaviour.

Test Plan:
- Post-reset, ports 3 and 7 pending, grant_ready=1, done pulsed 5 cycles after each grant -> grants in order 3, 7, 3, 7. First grant_valid 2 cycles after pointers differ.
- All 24 ports pending continuously -> grants cycle 0..23 then 0. No port is granted twice within any 24 consecutive grants.
- Port 5 granted, grant_ready held low 10 cycles -> grant_port stays 5 and grant_valid stays high. Raising rd_ptr_reset[5] -> abort pulse, grant_valid=0 next cycle, port 5 not regranted while reset.
- TIMEOUT_CYCLES=16, grant port 2 accepted, no done -> abort and timeout pulse on the 16th BUSY cycle. Next grant goes to the next pending port after 2.
- In BUSY for port 4, done with done_port=9 -> proto_err=1 and state stays BUSY. Then done with done_port=4 -> IDLE. Also done and rd_ptr_reset[4] in the same cycle -> no abort.
- LINECARD_SCHED_STATS_EN: after 3 grants to port 1, stats_sel=1 gives stats_grants=3 one cycle later. rst -> 0.

Source files
------------

// File: rtl/linecard_ingress_scheduler.sv
// linecard_ingress_scheduler
//
// This module is a round-robin scheduler for the line card's ingress FIFOs.
// On each cycle it registers which ports have committed data that the
// reader has not yet consumed. It offers one such port at a time to the
// cascaded-URAM FIFO reader over a valid/ready handshake. After the reader
// accepts, the port is held busy until the reader reports the frame done.
// A busy-state watchdog and a port-reset abort make sure the scheduler
// never stalls on a dead port.
//
// Optional feature macro: LINECARD_SCHED_STATS_EN
//   When it is defined, the module keeps a saturating 32-bit grant counter
//   per port. These counters are read through stats_sel / stats_grants.
//
// Ports:
//   clk, rst          fabric clock, synchronous active-high reset
//   port_en           per-port scheduling enable
//   rd_ptr_reset      per-port FIFO reset (high = port held in reset)
//   rd_ptr            reader's per-port read pointers
//   wr_ptr_committed  committed per-port write pointers
//   grant_valid/ready offer handshake towards the reader
//   grant_port        offered port index
//   done, done_port   reader reports the end of the granted frame
//   abort             one-cycle pulse when service is cancelled
//   timeout           one-cycle pulse when the watchdog expires
//   proto_err         sticky flag for an unexpected done
//   stats_sel         (stats build) port whose grant count is read
//   stats_grants      (stats build) grant count of stats_sel, one cycle later

module linecard_ingress_scheduler #(
    parameter  int NUM_PORTS      = 24,
    parameter  int PTR_BITS       = 13,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int PORT_BITS      = $clog2(NUM_PORTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                port_en,
    input  logic [NUM_PORTS-1:0]                rd_ptr_reset,
    input  logic [NUM_PORTS-1:0][PTR_BITS-1:0]  rd_ptr,
    input  logic [NUM_PORTS-1:0][PTR_BITS-1:0]  wr_ptr_committed,
    output logic                                grant_valid,
    input  logic                                grant_ready,
    output logic [PORT_BITS-1:0]                grant_port,
    input  logic                                done,
    input  logic [PORT_BITS-1:0]                done_port,
    output logic                                abort,
    output logic                                timeout,
`ifdef LINECARD_SCHED_STATS_EN
    input  logic [PORT_BITS-1:0]                stats_sel,
    output logic [31:0]                         stats_grants,
`endif
    output logic                                proto_err
);

    localparam int CNT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST =
        CNT_BITS'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [PORT_BITS-1:0] LAST_PORT = PORT_BITS'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_BUSY
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   pending_q, pending_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [PORT_BITS-1:0]   grant_port_q, grant_port_d;
    logic [PORT_BITS-1:0]   last_grant_q, last_grant_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   abort_q, abort_d;
    logic                   timeout_q, timeout_d;
    logic                   proto_err_q, proto_err_d;
    logic                   handshake;
    logic                   done_hit;
    logic                   port_in_reset;

`ifdef LINECARD_SCHED_STATS_EN
    logic [31:0]            stats_cnt_q [NUM_PORTS];
    logic [31:0]            stats_cnt_d [NUM_PORTS];
    logic [31:0]            stats_grants_q;
`endif

    // The round-robin search begins at the port after the last grant and
    // wraps around, so the first pending port found in that order wins.
    function automatic logic [PORT_BITS-1:0] rr_pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [PORT_BITS-1:0] last
    );
        logic [PORT_BITS-1:0] pick;
        logic                 found;
        logic [PORT_BITS:0]   idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = {1'b0, last} + (PORT_BITS+1)'(k);
            if (idx >= (PORT_BITS+1)'(NUM_PORTS)) begin
                idx = idx - (PORT_BITS+1)'(NUM_PORTS);
            end
            if (!found && req[idx[PORT_BITS-1:0]]) begin
                found = 1'b1;
                pick  = idx[PORT_BITS-1:0];
            end
        end
        return pick;
    endfunction

    // This block holds the next-state logic. A port is pending when it is
    // enabled, out of reset, and has unread committed data. An equality test
    // on the pointers is enough, so pointer wrap needs no special handling.
    // In BUSY, a matching done always wins over port reset and watchdog
    // expiry, so a frame that finishes on time is never reported as aborted.
    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_port_d  = grant_port_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        abort_d       = 1'b0;
        timeout_d     = 1'b0;
        proto_err_d   = proto_err_q;

        for (int i = 0; i < NUM_PORTS; i++) begin
            pending_d[i] = port_en[i] & ~rd_ptr_reset[i] &
                           (wr_ptr_committed[i] != rd_ptr[i]);
        end

        port_in_reset = rd_ptr_reset[grant_port_q];
        handshake     = (state_q == ST_OFFER) && grant_valid_q && grant_ready &&
                        !port_in_reset;
        done_hit      = done && (state_q == ST_BUSY) && (done_port == grant_port_q);

        if (done && !done_hit) begin
            proto_err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    grant_port_d  = rr_pick(pending_q, last_grant_q);
                    grant_valid_d = 1'b1;
                    state_d       = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (port_in_reset) begin
                    grant_valid_d = 1'b0;
                    abort_d       = 1'b1;
                    state_d       = ST_IDLE;
                end else if (handshake) begin
                    grant_valid_d = 1'b0;
                    last_grant_d  = grant_port_q;
                    cnt_d         = '0;
                    state_d       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (done_hit) begin
                    state_d = ST_IDLE;
                end else if (port_in_reset) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    abort_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

`ifdef LINECARD_SCHED_STATS_EN
    // The grant counters count accepted handshakes only, and each one
    // saturates instead of wrapping around.
    always_comb begin
        stats_cnt_d = stats_cnt_q;
        if (handshake && (stats_cnt_q[grant_port_q] != 32'hFFFF_FFFF)) begin
            stats_cnt_d[grant_port_q] = stats_cnt_q[grant_port_q] + 32'd1;
        end
    end
`endif

    // All scheduler state and registered outputs live in this block. After
    // reset, last_grant points at the highest port, so port 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            grant_valid_q <= 1'b0;
            grant_port_q  <= '0;
            last_grant_q  <= LAST_PORT;
            cnt_q         <= '0;
            abort_q       <= 1'b0;
            timeout_q     <= 1'b0;
            proto_err_q   <= 1'b0;
`ifdef LINECARD_SCHED_STATS_EN
            for (int i = 0; i < NUM_PORTS; i++) begin
                stats_cnt_q[i] <= 32'd0;
            end
            stats_grants_q <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            grant_valid_q <= grant_valid_d;
            grant_port_q  <= grant_port_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            abort_q       <= abort_d;
            timeout_q     <= timeout_d;
            proto_err_q   <= proto_err_d;
`ifdef LINECARD_SCHED_STATS_EN
            stats_cnt_q    <= stats_cnt_d;
            stats_grants_q <= stats_cnt_q[stats_sel];
`endif
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_port  = grant_port_q;
    assign abort       = abort_q;
    assign timeout     = timeout_q;
    assign proto_err   = proto_err_q;
`ifdef LINECARD_SCHED_STATS_EN
    assign stats_grants = stats_grants_q;
`endif

endmodule

// File: tb/tb_linecard_ingress_scheduler.sv
// tb_linecard_ingress_scheduler
//
// This bench drives pointer patterns into the scheduler and acts as the
// reader. Expected grant ports are queued when a pattern is applied and
// popped when the scheduler makes an offer.
// The design is instantiated with TIMEOUT_CYCLES = 16.

module tb_linecard_ingress_scheduler;

    localparam int NP = 24;
    localparam int PB = 13;
    localparam int PORTB = $clog2(NP);
    localparam int TO = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NP-1:0]         port_en;
    logic [NP-1:0]         rd_ptr_reset;
    logic [NP-1:0][PB-1:0] rd_ptr;
    logic [NP-1:0][PB-1:0] wr_ptr_committed;
    logic                  grant_valid;
    logic                  grant_ready;
    logic [PORTB-1:0]      grant_port;
    logic                  done;
    logic [PORTB-1:0]      done_port;
    logic                  abort;
    logic                  timeout;
    logic                  proto_err;
`ifdef LINECARD_SCHED_STATS_EN
    logic [PORTB-1:0]      stats_sel;
    logic [31:0]           stats_grants;
`endif

    int check_count = 0;
    int error_count = 0;
    int exp_q[$];

    linecard_ingress_scheduler #(
        .NUM_PORTS(NP),
        .PTR_BITS(PB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .port_en(port_en),
        .rd_ptr_reset(rd_ptr_reset),
        .rd_ptr(rd_ptr),
        .wr_ptr_committed(wr_ptr_committed),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready),
        .grant_port(grant_port),
        .done(done),
        .done_port(done_port),
        .abort(abort),
        .timeout(timeout),
`ifdef LINECARD_SCHED_STATS_EN
        .stats_sel(stats_sel),
        .stats_grants(stats_grants),
`endif
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one clock and sample/drive 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies a pending pattern: every port in the mask gets unread data.
    task automatic applyStimulus(input logic [NP-1:0] mask);
        for (int i = 0; i < NP; i++) begin
            rd_ptr[i]           = '0;
            wr_ptr_committed[i] = mask[i] ? PB'(1) : '0;
        end
    endtask

    task automatic doReset();
        rst          = 1'b1;
        port_en      = '1;
        rd_ptr_reset = '0;
        grant_ready  = 1'b1;
        done         = 1'b0;
        done_port    = '0;
`ifdef LINECARD_SCHED_STATS_EN
        stats_sel    = '0;
`endif
        applyStimulus('0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits for an offer and checks the offered port against the scoreboard.
    task automatic waitOffer(input string tag, output int waited);
        int exp_port;
        waited = 0;
        while (!grant_valid && waited < 60) begin
            tick();
            waited++;
        end
        if (!grant_valid) begin
            checkOutput({tag, "_offer_wait"}, 32'(grant_valid), 32'd1);
        end else begin
            exp_port = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checkOutput({tag, "_port"}, 32'(grant_port), 32'(exp_port));
        end
    endtask

    // Reader model: takes the offer and pulses done after done_delay cycles.
    task automatic serve(input string tag, input int done_delay);
        int w;
        waitOffer(tag, w);
        done_port = grant_port;
        tick();
        repeat (done_delay - 1) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        int w;
        int n;

        doReset();
        checkOutput("rst_grant_valid", 32'(grant_valid), 32'd0);
        checkOutput("rst_grant_port", 32'(grant_port), 32'd0);
        checkOutput("rst_abort", 32'(abort), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_proto_err", 32'(proto_err), 32'd0);

        // Ports 3 and 7 alternate; the first offer comes two cycles after the pointers differ.
        applyStimulus(NP'(24'h000088));
        exp_q.push_back(3);
        exp_q.push_back(7);
        exp_q.push_back(3);
        exp_q.push_back(7);
        waitOffer("rr37_first", w);
        checkOutput("latency", 32'(w), 32'd2);
        done_port = grant_port;
        tick();
        repeat (4) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 3; i++) serve("rr37", 5);

        // With every port pending, the grants sweep 0..23 and then return to 0.
        doReset();
        applyStimulus('1);
        for (int i = 0; i < NP; i++) exp_q.push_back(i);
        exp_q.push_back(0);
        for (int i = 0; i < NP + 1; i++) serve("sweep", 1);

        // Port 5 is offered while the reader is stalled, then the port is reset.
        doReset();
        grant_ready = 1'b0;
        applyStimulus(NP'(24'h000020));
        exp_q.push_back(5);
        waitOffer("stall", w);
        repeat (10) tick();
        checkOutput("stall_valid", 32'(grant_valid), 32'd1);
        checkOutput("stall_port", 32'(grant_port), 32'd5);
        rd_ptr_reset[5] = 1'b1;
        tick();
        checkOutput("prst_abort", 32'(abort), 32'd1);
        checkOutput("prst_valid", 32'(grant_valid), 32'd0);
        tick();
        checkOutput("prst_abort_low", 32'(abort), 32'd0);
        repeat (6) tick();
        checkOutput("prst_no_regrant", 32'(grant_valid), 32'd0);

        // The watchdog fires on the 16th busy cycle, and the next grant goes to port 6.
        doReset();
        applyStimulus(NP'(24'h000044));
        exp_q.push_back(2);
        waitOffer("wd", w);
        tick();
        n = 0;
        while (!timeout && n < 40) begin
            tick();
            n++;
        end
        checkOutput("wd_cycles", 32'(n), 32'(TO));
        checkOutput("wd_abort", 32'(abort), 32'd1);
        exp_q.push_back(6);
        serve("wd_next", 3);
        exp_q.push_back(2);
        serve("wd_after", 3);

        // A mismatched done sets proto_err; a matching done that coincides with a port reset does not abort.
        doReset();
        applyStimulus(NP'(24'h000010));
        exp_q.push_back(4);
        waitOffer("perr", w);
        tick();
        done      = 1'b1;
        done_port = 5'd9;
        tick();
        done      = 1'b0;
        checkOutput("perr_flag", 32'(proto_err), 32'd1);
        repeat (3) tick();
        checkOutput("perr_still_busy", 32'(grant_valid), 32'd0);
        done            = 1'b1;
        done_port       = 5'd4;
        rd_ptr_reset[4] = 1'b1;
        tick();
        done = 1'b0;
        checkOutput("done_vs_rst_abort", 32'(abort), 32'd0);
        tick();
        checkOutput("done_vs_rst_abort2", 32'(abort), 32'd0);
        checkOutput("perr_sticky", 32'(proto_err), 32'd1);

        // A reset in the middle of an offer clears everything without an abort pulse.
        rd_ptr_reset = '0;
        applyStimulus(NP'(24'h000001));
        grant_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_valid", 32'(grant_valid), 32'd0);
        checkOutput("midrst_perr", 32'(proto_err), 32'd0);
        checkOutput("midrst_abort", 32'(abort), 32'd0);

`ifdef LINECARD_SCHED_STATS_EN
        // Three grants to port 1 are counted, and rst clears the count.
        doReset();
        applyStimulus(NP'(24'h000002));
        for (int i = 0; i < 3; i++) exp_q.push_back(1);
        for (int i = 0; i < 3; i++) serve("stats", 2);
        grant_ready = 1'b0;
        stats_sel   = 5'd1;
        tick();
        checkOutput("stats_count", stats_grants, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("stats_cleared", stats_grants, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
